// File: rtl/cc_sel_pipe_if.sv
// Handshake bundle for cc_sel_pipe: qualified input beat on one side, the
// FIFO head on the other. master = the environment, slave = the pipe.
interface cc_sel_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic             en;
  logic             cmp_a;
  logic             cmp_b;
  logic             force_b;
  logic [WIDTH-1:0] pri_data;
  logic [WIDTH-1:0] sec_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_src;

  modport master (
    output in_valid, en, cmp_a, cmp_b, force_b, pri_data, sec_data, out_ready,
    input  in_ready, out_valid, out_data, out_src
  );

  modport slave (
    input  in_valid, en, cmp_a, cmp_b, force_b, pri_data, sec_data, out_ready,
    output in_ready, out_valid, out_data, out_src
  );
endinterface

// File: rtl/cc_sel_pipe.sv
// Registered source select: qualified beats pick primary/secondary data and
// queue into a small FIFO; dropped beats are counted, source switches flagged.
module cc_sel_pipe #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  cc_sel_pipe_if.slave     bus,
  output logic [CNT_W-1:0] drop_cnt,
  output logic             sw_evt,
  output logic [1:0]       cur_src
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PRI  = 2'b01,
    ST_SEC  = 2'b10
  } state_t;

  // Handshake: a beat transfers on any rising edge where valid & ready are
  // both high; ready never depends on valid, and in_ready never on out_ready.
  logic [WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             full, empty, acc, push, pop, sel_pri, src;
  logic [WIDTH-1:0] sel_data;
  state_t           state, state_nxt;
  logic             sw_nxt;

  assign full         = (count == FULL_CNT);
  assign empty        = (count == '0);
  assign bus.in_ready = ~full & ~rst;
  assign acc          = bus.in_valid & bus.in_ready;
  assign push         = acc & bus.en;
  assign pop          = bus.out_valid & bus.out_ready;

  assign sel_pri  = bus.cmp_a & bus.cmp_b & ~bus.force_b;
  assign sel_data = sel_pri ? bus.pri_data : bus.sec_data;
  assign src      = ~sel_pri;

  // Head is read straight from storage so it holds while stalled; zero when empty.
  assign bus.out_valid = ~empty;
  assign bus.out_data  = empty ? '0 : mem[rd_ptr][WIDTH-1:0];
  assign bus.out_src   = empty ? 1'b0 : mem[rd_ptr][WIDTH];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= {src, sel_data};
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (acc && !bus.en && drop_cnt != {CNT_W{1'b1}}) begin
      drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      sw_evt <= 1'b0;
    end else begin
      state  <= state_nxt;
      sw_evt <= sw_nxt;
    end
  end

  // Tracker only moves on pushed beats; the first beat after IDLE is not a switch.
  always_comb begin
    state_nxt = state;
    sw_nxt    = 1'b0;
    if (push) begin
      case (state)
        ST_IDLE: state_nxt = src ? ST_SEC : ST_PRI;
        ST_PRI: if (src) begin
          state_nxt = ST_SEC;
          sw_nxt    = 1'b1;
        end
        ST_SEC: if (!src) begin
          state_nxt = ST_PRI;
          sw_nxt    = 1'b1;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign cur_src = state;
endmodule

// File: tb/tb_cc_sel_pipe.sv
// Bench for cc_sel_pipe: directed scenarios plus random traffic, checked every
// cycle against a queue-based reference of the selection/FIFO/tracker rules.
module tb_cc_sel_pipe;
  localparam int WIDTH    = 8;
  localparam int DEPTH    = 4;
  localparam int CNT_W    = 8;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst;
  logic [CNT_W-1:0] drop_cnt;
  logic             sw_evt;
  logic [1:0]       cur_src;

  cc_sel_pipe_if #(.WIDTH(WIDTH)) bus ();

  cc_sel_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .drop_cnt (drop_cnt),
    .sw_evt   (sw_evt),
    .cur_src  (cur_src)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  logic [WIDTH:0] exp_q[$];
  int             m_drops;
  int             m_src;    // -1 none yet, 0 primary, 1 secondary
  int             m_sw;
  int             n_checks;
  int             n_pass;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [1:0] exp_cur();
    if (m_src < 0) return 2'b00;
    return (m_src == 0) ? 2'b01 : 2'b10;
  endfunction

  task automatic model_clear();
    exp_q.delete();
    m_drops = 0;
    m_src   = -1;
    m_sw    = 0;
  endtask

  // driver tasks
  task automatic drive(input logic v, input logic e, input logic a, input logic b,
                       input logic f, input logic [WIDTH-1:0] p, input logic [WIDTH-1:0] s,
                       input logic ordy);
    bus.in_valid  = v;
    bus.en        = e;
    bus.cmp_a     = a;
    bus.cmp_b     = b;
    bus.force_b   = f;
    bus.pri_data  = p;
    bus.sec_data  = s;
    bus.out_ready = ordy;
  endtask

  task automatic drive_random();
    drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0, $urandom_range(0, 3) != 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
          WIDTH'($urandom), WIDTH'($urandom), $urandom_range(0, 2) != 0);
  endtask

  // One clock: check outputs at the falling edge, advance the model, return at posedge+1.
  task automatic cycle();
    int             n;
    logic [WIDTH:0] head;
    logic           sel_pri, src, acc;
    @(negedge clk);
    n    = exp_q.size();
    head = (n != 0) ? exp_q[0] : '0;
    check("in_ready",  bus.in_ready,  n < DEPTH);
    check("out_valid", bus.out_valid, n != 0);
    check("out_data",  bus.out_data,  head[WIDTH-1:0]);
    check("out_src",   bus.out_src,   head[WIDTH]);
    check("drop_cnt",  drop_cnt,      m_drops);
    check("cur_src",   cur_src,       exp_cur());
    check("sw_evt",    sw_evt,        m_sw);
    acc  = bus.in_valid && (n < DEPTH);
    m_sw = 0;
    if (bus.out_ready && n != 0) void'(exp_q.pop_front());
    if (acc && bus.en) begin
      sel_pri = bus.cmp_a && bus.cmp_b && !bus.force_b;
      src     = !sel_pri;
      exp_q.push_back({src, sel_pri ? bus.pri_data : bus.sec_data});
      if (m_src >= 0 && m_src != int'(src)) m_sw = 1;
      m_src = int'(src);
    end else if (acc && m_drops < DROP_MAX) begin
      m_drops++;
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    model_clear();
    drive(0, 0, 0, 0, 0, '0, '0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data,  0);
    check("rst_cur_src",   cur_src,       0);
    rst = 1'b0;

    // 1: first beat from primary
    drive(1, 1, 1, 1, 0, 8'hA5, 8'h3C, 1);
    cycle();
    check("t1_data", bus.out_data, 8'hA5);
    check("t1_src",  bus.out_src,  0);
    check("t1_cur",  cur_src,      2'b01);
    check("t1_sw",   sw_evt,       0);

    // 2: switch to secondary, then stay
    drive(1, 1, 1, 1, 1, 8'hA5, 8'h3C, 1);
    cycle();
    check("t2_data", bus.out_data, 8'h3C);
    check("t2_src",  bus.out_src,  1);
    check("t2_cur",  cur_src,      2'b10);
    check("t2_sw",   sw_evt,       1);
    drive(1, 1, 0, 1, 0, 8'h11, 8'h22, 1);
    cycle();
    check("t2_sw_once", sw_evt, 0);
    drive(0, 1, 0, 0, 0, '0, '0, 1);
    repeat (3) cycle();

    // 3: fill with out_ready low, reject 5th, drain in order
    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, 0, 0, 1, 8'hFF, WIDTH'(k), 0);
      cycle();
    end
    check("t3_full", bus.in_ready, 0);
    drive(1, 1, 0, 0, 1, 8'hFF, 8'h05, 0);
    cycle();
    drive(0, 1, 0, 0, 0, '0, '0, 1);
    for (int k = 1; k <= 4; k++) begin
      check("t3_order", bus.out_data, k);
      cycle();
      if (k == 1) check("t3_ready_back", bus.in_ready, 1);
    end
    check("t3_empty", bus.out_valid, 0);

    // 4: drop saturation
    drive(1, 0, 1, 1, 0, 8'h55, 8'hAA, 1);
    repeat (300) cycle();
    check("t4_drop_sat", drop_cnt, DROP_MAX);
    check("t4_empty",    bus.out_valid, 0);
    check("t4_cur",      cur_src, 2'b10);

    // 5: steady stream
    for (int k = 0; k < 20; k++) begin
      drive(1, 1, 1, 1, 0, WIDTH'(8'h80 + k), 8'h00, 1);
      cycle();
      check("t5_no_bubble", bus.out_valid, 1);
    end
    drive(0, 1, 0, 0, 0, '0, '0, 1);
    cycle();

    // 6: async reset with beats queued
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 1, 1, 0, WIDTH'(8'h40 + k), 8'h00, 0);
      cycle();
    end
    drive(0, 0, 0, 0, 0, '0, '0, 0);
    #2 rst = 1'b1;
    #1;
    check("t6_out_valid", bus.out_valid, 0);
    check("t6_drop",      drop_cnt,      0);
    check("t6_cur",       cur_src,       0);
    check("t6_in_ready",  bus.in_ready,  0);
    model_clear();
    @(posedge clk);
    #1 rst = 1'b0;
    drive(1, 1, 1, 1, 0, 8'h77, 8'h00, 0);
    cycle();
    check("t6_latency", bus.out_data, 8'h77);
    drive(0, 1, 0, 0, 0, '0, '0, 1);
    repeat (2) cycle();

    // random traffic
    for (int k = 0; k < 2000; k++) begin
      drive_random();
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/cc_sel_pipe.md
Name: cc_sel_pipe

Overview:
- Registered, parametrised successor to the cc source-select logic.
- Each accepted input beat picks one of two WIDTH-bit sources using the enable/compare/force qualifiers: primary when en & cmp_a & cmp_b & ~force_b, otherwise secondary. Beats with en=0 are dropped.
- Selected beats go through a DEPTH-entry output FIFO with valid/ready handshakes on both sides.
- Also keeps a drop counter and a source-tracking state machine that flags primary/secondary switches.

Parameters:
- WIDTH, 8, data width of each source and of out_data.
- DEPTH, 4, output FIFO entries; power of 2, >= 2.
- CNT_W, 8, drop counter width.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  input beat offered.
- in_ready  out  1  input beat can be accepted.
- en  in  1  beat enable; 0 means drop the beat.
- cmp_a  in  1  compare qualifier A.
- cmp_b  in  1  compare qualifier B.
- force_b  in  1  forces the secondary source.
- pri_data  in  WIDTH  primary source data.
- sec_data  in  WIDTH  secondary source data.
- out_valid  out  1  FIFO head is valid.
- out_ready  in  1  downstream accepts the head.
- out_data  out  WIDTH  selected data at the FIFO head.
- out_src  out  1  source of the head beat: 0 = primary, 1 = secondary.
- drop_cnt  out  CNT_W  saturating count of dropped beats.
- sw_evt  out  1  one-cycle pulse when the source switches.
- cur_src  out  2  tracker state: 00 IDLE, 01 PRI, 10 SEC.

Behaviour:
- Reset (async assert, applied immediately):
  - FIFO emptied; out_valid=0, out_data=0, out_src=0.
  - drop_cnt=0, sw_evt=0, cur_src=IDLE.
  - Reset mid-operation discards all stored beats. No beat is accepted while rst is high.
- Accept condition: acc = in_valid & in_ready.
- in_ready = ~full. It does not depend on out_ready, so no push happens while full even if a pop occurs in the same cycle.
- Select, evaluated combinationally on the accepted beat:
  - sel_pri = cmp_a & cmp_b & ~force_b.
  - data = sel_pri ? pri_data : sec_data.
  - src = ~sel_pri.
- acc & en:
  - Push {src, data} into the FIFO.
  - Latency 1 cycle: if the FIFO was empty, out_valid=1 with that data on the next edge.
- acc & ~en:
  - No push.
  - drop_cnt increments, saturating at 2^CNT_W-1 (no wrap).
  - Tracker state unchanged.
- FIFO:
  - Pop on out_valid & out_ready.
  - Simultaneous push and pop with the FIFO neither empty nor full: occupancy unchanged and order preserved.
  - Push and pop when empty is not possible; out_valid is 0 at that point, so the push lands on the next edge.
  - Pointers are log2(DEPTH) bits and wrap naturally. full/empty come from a separate occupancy counter of log2(DEPTH)+1 bits.
  - out_data and out_src are held stable while out_valid=1 & out_ready=0.
- Tracker FSM, advancing only on acc & en:
  - IDLE -> PRI if src=0, IDLE -> SEC if src=1. No sw_evt on the first beat.
  - PRI -> SEC, or SEC -> PRI: sw_evt=1 for exactly the next cycle.
  - Same source again: stay in state, sw_evt=0.
  - sw_evt is registered and is 0 in every cycle not following a switch.
- Arithmetic:
  - All counters are unsigned.
  - drop_cnt saturation is checked before increment.
  - The occupancy counter never exceeds DEPTH and never goes below 0.

Test Plan:
1. Reset, then one beat: en=1, cmp_a=1, cmp_b=1, force_b=0, pri_data=0xA5, sec_data=0x3C, out_ready=1 -> next cycle out_valid=1, out_data=0xA5, out_src=0, cur_src=01, sw_evt=0.
2. Following beat with force_b=1, sec_data=0x3C -> out_data=0x3C, out_src=1, cur_src=10, sw_evt=1 for exactly one cycle. Next beat from secondary -> sw_evt=0.
3. Hold out_ready=0 and push 4 beats 0x01..0x04 (DEPTH=4) -> in_ready=0 after the 4th; a 5th in_valid is not accepted. Release out_ready -> 0x01..0x04 come out in order, one per cycle, and in_ready returns 1 after the first pop.
4. CNT_W=8: 300 beats with en=0 -> drop_cnt=255 (saturated), FIFO stays empty, cur_src unchanged.
5. Steady stream with in_valid=1 and out_ready=1 for 20 cycles, occupancy 1 -> one beat per cycle, data in order, no bubbles after the first.
6. Assert rst asynchronously (mid-cycle) with 3 beats queued -> out_valid=0, drop_cnt=0, cur_src=00 immediately. After release, the first beat appears one cycle after acceptance.
